// File: rtl/bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  // Decimal digits needed for 2**width-1: ceil(width * log10(2)),
  // using a fixed-point approximation of log10(2).
  function automatic int bcd_digits_for(input int width);
    longint scaled;
    scaled = longint'(width) * 64'd30103 + 64'd99999;
    return int'(scaled / 64'd100000);
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= bcd_digit_t'(5)) ? bcd_digit_t'(din + bcd_digit_t'(3)) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per clock,
// with valid/ready on both sides. Result held until out_ready.
// Optional: define BIN2BCD_SIGNED_EN to treat binary as two's complement
// (magnitude converted, sign reported on neg).
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             binary,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                         neg,
  output logic                         ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = BCD_DIGIT_W * DIGITS;

  bcd_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [WIDTH-1:0]      shreg;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_fix;
  logic                  ovf_acc;

  logic [ACC_W+WIDTH:0]  shifted;
  logic [ACC_W-1:0]      acc_nxt;
  logic [WIDTH-1:0]      sh_nxt;
  logic                  carry;
  logic                  accept;
  logic                  last;
  logic [WIDTH-1:0]      load_val;

  // Per-digit add-3 correction ahead of each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3_digit u_add3 (
      .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (acc_fix[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // {acc, bin} shifted left by one; the bit leaving the top digit is the overflow carry
  assign shifted = {acc_fix, shreg, 1'b0};
  assign carry   = shifted[ACC_W+WIDTH];
  assign acc_nxt = shifted[ACC_W+WIDTH-1:WIDTH];
  assign sh_nxt  = shifted[WIDTH-1:0];

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNT_W'(1));

`ifdef BIN2BCD_SIGNED_EN
  logic neg_acc;

  // Convert the magnitude; most-negative value wraps to its unsigned magnitude
  assign load_val = binary[WIDTH-1] ? WIDTH'(-binary) : binary;

  // Sign captured at accept, published together with the BCD result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_acc <= 1'b0;
      neg     <= 1'b0;
    end else begin
      if (accept) neg_acc <= binary[WIDTH-1];
      if (state == SHIFT && last) neg <= neg_acc;
    end
  end
`else
  assign load_val = binary;
  assign neg      = 1'b0;
`endif

  // Conversion FSM: accept, shift WIDTH times, hold result until handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      bcd       <= '0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          acc     <= acc_nxt;
          shreg   <= sh_nxt;
          ovf_acc <= ovf_acc | carry;
          cnt     <= cnt - 1'b1;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            bcd       <= acc_nxt;
            ovf       <= ovf_acc | carry;
          end
        end
        IDLE, DONE: begin
          if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          // Accept wins over the return to IDLE for zero-bubble back-to-back
          if (accept) begin
            shreg   <= load_val;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CNT_W'(WIDTH);
            state   <= SHIFT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (default 16-bit / 5 digits,
// plus a 4-digit instance for the overflow case).
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, neg, ovf;
  logic [15:0] binary;
  logic [19:0] bcd;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, neg2, ovf2;
  logic [15:0] binary2;
  logic [15:0] bcd2;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .binary(binary), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .neg(neg), .ovf(ovf)
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .binary(binary2), .out_valid(out_valid2), .out_ready(out_ready2),
    .bcd(bcd2), .neg(neg2), .ovf(ovf2)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present v for one accept edge, then wait (bounded) for out_valid.
  // lat = clocks from accept edge to out_valid, -1 on timeout.
  task automatic run(input bit sel, input logic [15:0] v, output int lat);
    if (sel) begin in_valid2 = 1'b1; binary2 = v; end
    else     begin in_valid  = 1'b1; binary  = v; end
    tick;
    in_valid = 1'b0; in_valid2 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (sel ? out_valid2 : out_valid) begin lat = n; break; end
    end
  endtask

  initial begin
    int          lat;
    bit          seen;
    logic [15:0] vals [4];
    logic [19:0] expb [4];

    rst = 1'b1; in_valid = 1'b0; binary = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; binary2 = '0; out_ready2 = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    tick;

    // reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_bcd",       bcd,       0);
    check("rst_ovf",       ovf,       0);
    check("rst_neg",       neg,       0);
    check("rst4_in_ready", in_ready2, 1);

    // 1: 5555, latency 16
    run(0, 16'd5555, lat);
    check("t1_lat", lat, 16);
    check("t1_bcd", bcd, 20'h05555);
    check("t1_ovf", ovf, 0);
    tick;
    check("t1_released", out_valid, 0);

    // zero still takes full latency
    run(0, 16'd0, lat);
    check("zero_lat", lat, 16);
    check("zero_bcd", bcd, 0);
    check("zero_ovf", ovf, 0);
    tick;

    // 2: back-to-back with in_valid held
    vals = '{16'd1234, 16'd9876, 16'd2025, 16'd65535};
`ifdef BIN2BCD_SIGNED_EN
    expb = '{20'h01234, 20'h09876, 20'h02025, 20'h00001};
`else
    expb = '{20'h01234, 20'h09876, 20'h02025, 20'h65535};
`endif
    binary = vals[0]; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("t2_ov_drop", out_valid, 0);
      if (i < 3) binary = vals[i+1];
      else       in_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
        tick;
        if (out_valid) begin lat = n; break; end
      end
      check("t2_lat", lat, 16);
      check("t2_bcd", bcd, expb[i]);
      check("t2_in_ready", in_ready, 1);
    end
`ifdef BIN2BCD_SIGNED_EN
    check("t2_neg", neg, 1);
`else
    check("t2_neg", neg, 0);
`endif
    tick;

    // 3: backpressure
    out_ready = 1'b0;
    run(0, 16'd3000, lat);
    check("t3_lat", lat, 16);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; binary = 16'd7;
      tick;
      check("t3_bcd_hold",  bcd,       20'h03000);
      check("t3_in_ready",  in_ready,  0);
      check("t3_out_valid", out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    check("t3_handshake", out_valid, 0);
    check("t3_idle_rdy",  in_ready,  1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    check("t3_no_extra", seen, 0);

    // 4: 4-digit instance overflow then clean
    run(1, 16'd12345, lat);
    check("t4_lat", lat, 16);
    check("t4_ovf", ovf2, 1);
    check("t4_bcd", bcd2, 16'h2345);
    run(1, 16'd42, lat);
    check("t4b_ovf", ovf2, 0);
    check("t4b_bcd", bcd2, 16'h0042);
    tick;

    // 5: reset mid-conversion
    in_valid = 1'b1; binary = 16'hFFFF;
    tick;
    in_valid = 1'b0;
    repeat (7) tick;
    rst = 1'b1;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_bcd",       bcd,       0);
    check("t5_in_ready",  in_ready,  1);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    check("t5_aborted", seen, 0);
    run(0, 16'd100, lat);
    check("t5_lat", lat, 16);
    check("t5_bcd_next", bcd, 20'h00100);
    tick;

`ifdef BIN2BCD_SIGNED_EN
    // 6: signed inputs
    run(0, 16'hF817, lat);
    check("t6_lat", lat, 16);
    check("t6_neg", neg, 1);
    check("t6_bcd", bcd, 20'h02025);
    tick;
    run(0, 16'h8000, lat);
    check("t6_min_neg", neg, 1);
    check("t6_min_bcd", bcd, 20'h32768);
    tick;
    run(0, 16'd0, lat);
    check("t6_zero_neg", neg, 0);
    check("t6_zero_bcd", bcd, 0);
    tick;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
